frac_stepper: RTL



---
 rtl/frac_stepper_pkg.sv | 15 +
 rtl/frac_stepper_div.sv | 75 +++++++
 rtl/frac_stepper.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/frac_stepper_pkg.sv
// Shared constants for the fractional source stepper: alignment modes and
// controller state encodings.
package frac_stepper_pkg;

  localparam logic [1:0] MODE_LEFT   = 2'd0;
  localparam logic [1:0] MODE_CENTRE = 2'd1;
  localparam logic [1:0] MODE_RIGHT  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

endpackage

// File: rtl/frac_stepper_div.sv
// Restoring unsigned divider, one quotient bit per cycle. A req restarts it
// (aborting any divide in flight); ack pulses once the NW-bit quotient is final.
module frac_stepper_div #(
  parameter int unsigned NW = 26,
  parameter int unsigned DW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          ack_o,
  output logic [NW-1:0] quot_o,
  output logic          dz_o
);

  localparam int unsigned CW = $clog2(NW + 1);

  logic [NW-1:0] dvd_q, quo_q;
  logic [DW-1:0] dvs_q, rem_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, ack_q, dz_q;
  logic [DW:0]   shifted, trial;

  // The partial remainder stays below the divisor, so DW+1 bits hold the
  // shifted value and the top bit of the difference is the borrow.
  always_comb begin
    shifted = {rem_q, dvd_q[NW-1]};
    trial   = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      ack_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else if (req_i) begin
      dvd_q  <= dividend_i;
      dvs_q  <= divisor_i;
      quo_q  <= '0;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      ack_q  <= 1'b0;
      dz_q   <= (divisor_i == '0);
    end else begin
      ack_q <= 1'b0;
      if (busy_q) begin
        dvd_q <= {dvd_q[NW-2:0], 1'b0};
        if (!trial[DW]) begin
          rem_q <= trial[DW-1:0];
          quo_q <= {quo_q[NW-2:0], 1'b1};
        end else begin
          rem_q <= shifted[DW-1:0];
          quo_q <= {quo_q[NW-2:0], 1'b0};
        end
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == CW'(NW - 1)) begin
          busy_q <= 1'b0;
          ack_q  <= 1'b1;
        end
      end
    end
  end

  assign ack_o  = ack_q;
  assign quot_o = dz_q ? '1 : quo_q;
  assign dz_o   = dz_q;

endmodule

// File: rtl/frac_stepper.sv
// Fractional source-stepping engine: divides num/den into a fixed-point step,
// then walks destination slots reporting source pixel advances and phases.
module frac_stepper
  import frac_stepper_pkg::*;
#(
  parameter int unsigned BITWIDTH  = 10,
  parameter int unsigned FRACWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITWIDTH-1:0]  num,
  input  logic [BITWIDTH-1:0]  den,
  input  logic [BITWIDTH-1:0]  limit,
  input  logic [BITWIDTH-1:0]  span,
  input  logic [1:0]           mode,
  input  logic                 newfraction,
  output logic                 ready,
  output logic                 err,
  input  logic                 step_reset,
  input  logic                 step_in,
  output logic                 step_out,
  output logic [BITWIDTH-1:0]  whole,
  output logic [FRACWIDTH-1:0] fraction,
  output logic                 blank
);

  localparam int unsigned W = BITWIDTH + FRACWIDTH;

  state_e               state_q;
  logic [BITWIDTH-1:0]  num_q, limit_q, span_q, off_q, dpos_q;
  logic [1:0]           mode_q;
  logic [W-1:0]         step_q, spos_q;
  logic [BITWIDTH:0]    nidx_q;
  logic                 done_q;
  logic                 ready_q, err_q, step_out_q, blank_q;
  logic [BITWIDTH-1:0]  whole_q;
  logic [FRACWIDTH-1:0] fraction_q;

  logic                 div_ack, div_dz;
  logic [W-1:0]         div_quot;
  logic [BITWIDTH-1:0]  off_d, dpos_d;
  logic                 done_d, restart;

  frac_stepper_div #(
    .NW(W),
    .DW(BITWIDTH)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .req_i     (newfraction),
    .dividend_i({num, {FRACWIDTH{1'b0}}}),
    .divisor_i (den),
    .ack_o     (div_ack),
    .quot_o    (div_quot),
    .dz_o      (div_dz)
  );

  // Difference taken one bit wider so an image larger than the span shows
  // up as a borrow and collapses the offset to zero.
  function automatic logic [BITWIDTH-1:0] lead_offset(
    input logic [BITWIDTH-1:0] s,
    input logic [BITWIDTH-1:0] n,
    input logic [1:0]          m
  );
    logic [BITWIDTH:0]   diff;
    logic [BITWIDTH-1:0] res;
    diff = {1'b0, s} - {1'b0, n};
    res  = '0;
    if (!diff[BITWIDTH]) begin
      case (m)
        MODE_CENTRE: res = diff[BITWIDTH:1];
        MODE_RIGHT:  res = diff[BITWIDTH-1:0];
        default:     res = '0;
      endcase
    end
    return res;
  endfunction

  always_comb begin
    off_d   = lead_offset(span_q, num_q, mode_q);
    dpos_d  = dpos_q + 1'b1;
    done_d  = (num_q == '0) || div_dz;
    restart = ((state_q == ST_DIVIDE) && div_ack) ||
              ((state_q == ST_RUN) && step_reset);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      limit_q    <= '0;
      span_q     <= '0;
      mode_q     <= MODE_LEFT;
      off_q      <= '0;
      dpos_q     <= '0;
      step_q     <= '0;
      spos_q     <= '0;
      nidx_q     <= '0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      step_out_q <= 1'b0;
      whole_q    <= '0;
      fraction_q <= '0;
      blank_q    <= 1'b1;
    end else begin
      step_out_q <= 1'b0;
      if (newfraction) begin
        num_q   <= num;
        limit_q <= limit;
        span_q  <= span;
        mode_q  <= mode;
        err_q   <= (den == '0) || (num < den);
        ready_q <= 1'b0;
        blank_q <= 1'b1;
        state_q <= ST_DIVIDE;
      end else if (restart) begin
        state_q    <= ST_RUN;
        ready_q    <= 1'b1;
        step_q     <= div_quot;
        spos_q     <= '0;
        dpos_q     <= '0;
        nidx_q     <= '0;
        whole_q    <= '0;
        done_q     <= done_d;
        off_q      <= off_d;
        blank_q    <= 1'b1;
        fraction_q <= '0;
      end else if ((state_q == ST_RUN) && step_in) begin
        if (off_q != '0) begin
          off_q      <= off_q - 1'b1;
          blank_q    <= 1'b1;
          fraction_q <= '0;
        end else if (done_q) begin
          blank_q    <= 1'b1;
          fraction_q <= '0;
        end else begin
          dpos_q <= dpos_d;
          if (dpos_d == num_q) done_q <= 1'b1;
          if (dpos_q >= spos_q[W-1:FRACWIDTH]) begin
            if (nidx_q > {1'b0, limit_q}) begin
              done_q     <= 1'b1;
              blank_q    <= 1'b1;
              fraction_q <= '0;
            end else begin
              step_out_q <= 1'b1;
              fraction_q <= spos_q[FRACWIDTH-1:0];
              whole_q    <= nidx_q[BITWIDTH-1:0];
              nidx_q     <= nidx_q + 1'b1;
              spos_q     <= spos_q + step_q;
              blank_q    <= 1'b0;
            end
          end else begin
            blank_q    <= 1'b0;
            fraction_q <= '0;
          end
        end
      end else if (step_in) begin
        blank_q <= 1'b1;
      end
    end
  end

  assign ready    = ready_q;
  assign err      = err_q;
  assign step_out = step_out_q;
  assign whole    = whole_q;
  assign fraction = fraction_q;
  assign blank    = blank_q;

endmodule
